j1_uart_io: RTL and testbench
=============================

// Module: j1_uart_io
// PURPOSE
//   I/O-space peripheral consuming the j1 core's io bus: decodes io writes, returns io reads
//   and implements a byte UART (TX holding register + shifter, RX deserialiser + status).
//   The j1 presents the next T as io_addr every cycle, so the block registers it. An io@ / io!
//   instruction then acts on the registered address, which equals T during that instruction.
// PARAMETERS
//   WIDTH      32          data width of io_dout / io_din (matches core WIDTH)
//   CLK_HZ     12000000    clk frequency, Hz
//   BAUD       115200      line rate; DIV = CLK_HZ/BAUD clocks per bit (integer, >= 4)
//   ADDR_DATA  16'h1000    UART data register address
//   ADDR_STAT  16'h2000    UART status/control register address
// PORTS
//   clk       in   1      system clock, all logic on rising edge
//   reset     in   1      synchronous, active-high reset
//   io_wr     in   1      core io write strobe (one cycle per io! instruction)
//   io_addr   in   16     core next-T address (j1 mem_addr), sampled every cycle
//   io_dout   in   WIDTH  core write data (N)
//   io_din    out  WIDTH  read data to core, combinational from addr_q and registers
//   uart_rx   in   1      async serial input, idle high
//   uart_tx   out  1      serial output, idle high
// BEHAVIOUR
//   Reset: addr_q=0, uart_tx=1, tx_full=0, tx FSM IDLE, rx FSM IDLE, rx_data=0, all flags 0,
//     sync flops=1; io_din=0 unless a parameter address equals 0.
//   addr_q <= io_addr every cycle; all decode below uses addr_q, never io_addr directly.
//   Reads (no side effects): addr_q==ADDR_DATA -> {0,rx_data[7:0]};
//     ADDR_STAT -> {0,ferr,ovr,rx_valid,tx_ready} in bits [3:0]; other addresses -> 0.
//   tx_ready = !tx_full.
//   Write ADDR_DATA: if !tx_full, hold <= io_dout[7:0], tx_full<=1; if tx_full, write dropped.
//   Write ADDR_STAT: io_dout bit1=1 clears rx_valid, bit2 clears ovr, bit3 clears ferr;
//     zero bits leave flags; other bits ignored. Writes to other addresses ignored.
//   TX FSM IDLE->START->DATA->STOP->IDLE, each bit exactly DIV clocks, LSB first:
//     IDLE with tx_full: shifter<=hold, tx_full<=0 (same edge), uart_tx=0 next cycle.
//     DATA shifts 8 bits; STOP drives 1 for DIV clocks. At end of STOP with tx_full set, goes
//     straight to START (no idle gap). io_wr in the cycle tx_full clears is accepted.
//   RX: 2-flop synchroniser on uart_rx. FSM IDLE->START->DATA->STOP:
//     IDLE: synced line 0 -> START, counter = DIV/2.
//     START: at half-bit re-sample; 1 -> IDLE (glitch, no flag), 0 -> DATA.
//     DATA: sample every DIV clocks, 8 bits LSB first.
//     STOP: sample after DIV; if 1: rx_data<=byte, rx_valid<=1, ovr<=1 if rx_valid already
//       set (new byte overwrites); if 0: byte discarded, ferr<=1; IDLE then waits line high.
//   Same-cycle STAT clear of rx_valid and new byte completion: set wins (rx_valid=1, ovr=0).
//   Reset mid-frame: both FSMs abort immediately, uart_tx=1 next cycle, partial byte lost.
//   Counters: bit counter 3 bits, baud counter $clog2(DIV) bits, reload on every bit edge.
// TESTING (CLK_HZ=1000, BAUD=100 -> DIV=10)
//   Reset -> uart_tx=1; addr 0x2000 reads 0x1 (tx_ready only).
//   Write 0x1000 data 0x55 -> uart_tx low 10 clk, bits 1,0,1,0,1,0,1,0 (10 clk each), high.
//   Write 0xA5 then 0x3C back-to-back, then 0x77 while full -> 0xA5, 0x3C frames contiguous;
//     0x77 never sent.
//   Drive RX frame 0xC3 at DIV=10 -> STAT=0x3, DATA=0xC3; second frame 0x81 unread -> STAT=0x7,
//     DATA=0x81; write STAT 0x6 -> STAT=0x1.
//   RX stop bit 0 -> ferr (STAT bit3) set, DATA unchanged; 3-clk low glitch on rx -> no flags.
//   Assert reset mid-TX bit 4 -> uart_tx=1 next cycle, STAT=0x1 after release.

Source files
------------

// File: rtl/j1_uart_io.sv
// I/O-space peripheral for the j1 core: registered io address decode plus a byte UART
// with a single holding register on TX and a status-flagged deserialiser on RX.
module j1_uart_io #(
  parameter int          WIDTH     = 32,
  parameter int          CLK_HZ    = 12000000,
  parameter int          BAUD      = 115200,
  parameter logic [15:0] ADDR_DATA = 16'h1000,
  parameter logic [15:0] ADDR_STAT = 16'h2000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_wr,
  input  logic [15:0]      io_addr,
  input  logic [WIDTH-1:0] io_dout,
  output logic [WIDTH-1:0] io_din,
  input  logic             uart_rx,
  output logic             uart_tx
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

  logic [15:0]   addr_q;
  uart_st_e      tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;
  logic          tx_full_q, tx_full_d, tx_q, tx_d, tx_load;

  logic          sync1_q, sync2_q, rx_arm_q, rx_arm_d;
  uart_st_e      rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d, ovr_q, ovr_d, ferr_q, ferr_d;

  logic wr_data, wr_stat, tx_tick, rx_tick, unused_dout;

  assign wr_data     = io_wr && (addr_q == ADDR_DATA);
  assign wr_stat     = io_wr && (addr_q == ADDR_STAT);
  assign tx_tick     = (tx_cnt_q == '0);
  assign rx_tick     = (rx_cnt_q == '0);
  assign uart_tx     = tx_q;
  assign unused_dout = ^io_dout[WIDTH-1:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      tx_st_q    <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_full_q  <= 1'b0;
      tx_q       <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_arm_q   <= 1'b1;
      rx_st_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      addr_q     <= io_addr;
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_full_q  <= tx_full_d;
      tx_q       <= tx_d;
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      rx_arm_q   <= rx_arm_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  // Shift/holding registers carry data only; their contents are qualified by the FSMs.
  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    tx_hold_q  <= tx_hold_d;
    rx_shift_q <= rx_shift_d;
  end

  always_comb begin
    tx_st_d    = tx_st_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    case (tx_st_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        tx_load = tx_full_q;
      end
      S_START: begin
        if (tx_tick) begin
          tx_st_d  = S_DATA;
          tx_cnt_d = BIT_LAST;
          tx_bit_d = '0;
          tx_d     = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      S_DATA: begin
        if (tx_tick) begin
          tx_cnt_d = BIT_LAST;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      default: begin
        if (tx_tick) begin
          if (tx_full_q) tx_load = 1'b1;
          else           tx_st_d = S_IDLE;
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
    endcase
    // A pending byte starts its frame straight away, with no idle gap after a stop bit.
    if (tx_load) begin
      tx_st_d    = S_START;
      tx_cnt_d   = BIT_LAST;
      tx_shift_d = tx_hold_q;
      tx_full_d  = 1'b0;
      tx_d       = 1'b0;
    end
    if (wr_data && (!tx_full_q || tx_load)) begin
      tx_hold_d = io_dout[7:0];
      tx_full_d = 1'b1;
    end
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_arm_d   = rx_arm_q;
    rx_valid_d = rx_valid_q && !(wr_stat && io_dout[1]);
    ovr_d      = ovr_q && !(wr_stat && io_dout[2]);
    ferr_d     = ferr_q && !(wr_stat && io_dout[3]);
    case (rx_st_q)
      S_IDLE: begin
        if (sync2_q) rx_arm_d = 1'b1;
        else if (rx_arm_q) begin
          rx_st_d  = S_START;
          rx_cnt_d = HALF_LAST;
        end
      end
      S_START: begin
        if (rx_tick) begin
          if (sync2_q) rx_st_d = S_IDLE;
          else begin
            rx_st_d  = S_DATA;
            rx_cnt_d = BIT_LAST;
            rx_bit_d = '0;
          end
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
          else                  rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      default: begin
        if (rx_tick) begin
          rx_st_d = S_IDLE;
          // Completion overrides a same-cycle clear: overrun only if the old byte survives it.
          if (sync2_q) begin
            rx_data_d  = rx_shift_q;
            ovr_d      = ovr_d || rx_valid_d;
            rx_valid_d = 1'b1;
          end else begin
            ferr_d   = 1'b1;
            rx_arm_d = 1'b0;
          end
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
    endcase
  end

  always_comb begin
    io_din = '0;
    if (addr_q == ADDR_DATA)      io_din[7:0] = rx_data_q;
    else if (addr_q == ADDR_STAT) io_din[3:0] = {ferr_q, ovr_q, rx_valid_q, !tx_full_q};
  end

endmodule

// File: tb/tb_j1_uart_io.sv
// Scoreboard bench for j1_uart_io: TX frames and io reads are predicted by a
// frame-level reference model and checked by independent monitor processes.
module tb_j1_uart_io;
  localparam int WIDTH = 32;
  localparam int DIV   = 10;
  localparam logic [15:0] A_DATA = 16'h1000;
  localparam logic [15:0] A_STAT = 16'h2000;

  logic        clk = 1'b0, reset = 1'b1, io_wr = 1'b0, uart_rx = 1'b1;
  logic [15:0] io_addr = '0;
  logic [31:0] io_dout = '0;
  logic [31:0] io_din;
  logic        uart_tx;

  j1_uart_io #(.WIDTH(WIDTH), .CLK_HZ(1000), .BAUD(100),
               .ADDR_DATA(A_DATA), .ADDR_STAT(A_STAT)) dut (
    .clk(clk), .reset(reset), .io_wr(io_wr), .io_addr(io_addr), .io_dout(io_dout),
    .io_din(io_din), .uart_rx(uart_rx), .uart_tx(uart_tx));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one holding slot, a frame occupies the line for 10*DIV clocks.
  int         cyc = 0, m_free_at = 0;
  logic [15:0] m_addr = '0;
  logic       m_full = 1'b0;
  logic [7:0] m_hold = '0;
  logic [7:0] txq_byte[$];
  int         txq_time[$];
  logic       m_valid = 0, m_ovr = 0, m_ferr = 0;
  logic [7:0] m_rxdata = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_addr = '0; m_full = 1'b0; m_free_at = 0;
      txq_byte.delete(); txq_time.delete();
    end else begin
      if (m_full && cyc >= m_free_at) begin
        txq_byte.push_back(m_hold); txq_time.push_back(cyc);
        m_full = 1'b0; m_free_at = cyc + 10 * DIV;
      end
      if (io_wr && m_addr == A_DATA && !m_full) begin
        m_hold = io_dout[7:0]; m_full = 1'b1;
      end
      m_addr = io_addr;
    end
  end

  // TX line monitor
  logic       mon_act = 1'b0, exp_bit;
  int         mon_t = 0, mon_err = 0;
  logic [7:0] mon_exp = '0, mon_got = '0;
  always @(negedge clk) begin
    if (reset) mon_act = 1'b0;
    else begin
      if (!mon_act && uart_tx === 1'b0) begin
        if (txq_byte.size() == 0) begin
          check("tx_unexpected_frame", 32'(txq_byte.size()), 32'd1);
          mon_exp = 8'h00;
        end else begin
          mon_exp = txq_byte.pop_front();
          check("tx_frame_start_cycle", 32'(cyc), 32'(txq_time.pop_front()));
        end
        mon_act = 1'b1; mon_t = 0; mon_err = 0; mon_got = '0;
      end
      if (mon_act) begin
        if (mon_t < DIV) exp_bit = 1'b0;
        else if (mon_t < 9 * DIV) exp_bit = mon_exp[3'((mon_t - DIV) / DIV)];
        else exp_bit = 1'b1;
        if (uart_tx !== exp_bit) mon_err++;
        if (mon_t >= DIV && mon_t < 9 * DIV && (mon_t % DIV) == DIV / 2)
          mon_got[3'((mon_t - DIV) / DIV)] = uart_tx;
        if (mon_t == 10 * DIV - 1) begin
          check("tx_frame_byte", 32'(mon_got), 32'(mon_exp));
          check("tx_frame_bit_errors", 32'(mon_err), 32'd0);
          mon_act = 1'b0;
        end
        mon_t++;
      end
    end
  end

  // Read monitor
  logic        rd_vld = 1'b0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  always @(negedge clk) begin
    if (rd_vld) begin
      if (rd_exp_q.size() == 0) check("rd_no_expectation", 32'd0, 32'd1);
      else check(rd_name_q.pop_front(), io_din, rd_exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd(string name, logic [15:0] a);
    logic [31:0] e;
    io_addr = a; tick();
    e = '0;
    if (a == A_DATA) e[7:0] = m_rxdata;
    else if (a == A_STAT) e[3:0] = {m_ferr, m_ovr, m_valid, !m_full};
    rd_exp_q.push_back(e); rd_name_q.push_back(name);
    rd_vld = 1'b1; tick(); rd_vld = 1'b0;
  endtask

  task automatic wr(logic [15:0] a, logic [31:0] d);
    io_addr = a; tick();
    io_wr = 1'b1; io_dout = d; tick(); io_wr = 1'b0;
    if (a == A_STAT) begin
      if (d[1]) m_valid = 1'b0;
      if (d[2]) m_ovr = 1'b0;
      if (d[3]) m_ferr = 1'b0;
    end
  endtask

  task automatic rx_send(logic [7:0] b, logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i]; repeat (DIV) tick();
    end
    uart_rx = 1'b1; repeat (DIV) tick();
    if (stop) begin
      m_ovr = m_ovr | m_valid; m_valid = 1'b1; m_rxdata = b;
    end else m_ferr = 1'b1;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while ((txq_byte.size() != 0 || mon_act || m_full) && n < 3000) begin
      tick(); n++;
    end
    check(name, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    repeat (3) tick();
    reset = 1'b0;
    check("tx_idle_after_reset", 32'(uart_tx), 32'd1);
    rd("stat_after_reset", A_STAT);
    rd("data_after_reset", A_DATA);
    rd("addr0_read", 16'h0000);
    rd("unmapped_read", 16'h1234);

    wr(A_DATA, 32'hFFFF_FF55);
    rd("stat_tx_busy", A_STAT);
    drain("drain_single");

    io_addr = A_DATA; tick();
    io_wr = 1'b1; io_dout = 32'hA5; tick();
    io_dout = 32'h3C; tick();
    io_dout = 32'h77; tick();
    io_wr = 1'b0;
    rd("stat_hold_full", A_STAT);
    drain("drain_burst");

    for (int i = 0; i < 8; i++) begin
      wr(A_DATA, $urandom);
      repeat ($urandom_range(0, 150)) tick();
    end
    drain("drain_random_tx");

    rx_send(8'hC3, 1'b1);
    rd("stat_rx_first", A_STAT);
    rd("data_rx_first", A_DATA);
    rx_send(8'h81, 1'b1);
    rd("stat_rx_overrun", A_STAT);
    rd("data_rx_overrun", A_DATA);
    wr(A_STAT, 32'h6);
    rd("stat_after_clear", A_STAT);

    rx_send(8'h5A, 1'b0);
    rd("stat_framing_err", A_STAT);
    rd("data_after_ferr", A_DATA);
    wr(A_STAT, 32'h8);
    uart_rx = 1'b0; repeat (3) tick();
    uart_rx = 1'b1; repeat (2 * DIV) tick();
    rd("stat_after_glitch", A_STAT);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      rx_send(b, $urandom_range(0, 3) != 0);
      rd("stat_rx_random", A_STAT);
      rd("data_rx_random", A_DATA);
      if ($urandom_range(0, 1) == 1) wr(A_STAT, 32'($urandom_range(0, 15)));
    end

    wr(A_DATA, 32'h00);
    repeat (55) tick();
    check("tx_low_in_bit4", 32'(uart_tx), 32'd0);
    reset = 1'b1; tick();
    check("tx_high_after_reset", 32'(uart_tx), 32'd1);
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_rxdata = '0;
    tick(); reset = 1'b0; tick();
    rd("stat_after_mid_reset", A_STAT);
    rd("data_after_mid_reset", A_DATA);
    drain("drain_final");
    repeat (3) tick();
    check("rd_queue_empty", 32'(rd_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
